// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration-write arbiter.
// Also provides a helper that packs a codec register address and value into one 16-bit word.
package codec_cfg_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, GAP} cfg_state_e;

  localparam logic [7:0] DEF_SLAVE_ADDR = 8'h34;

  // Codec register map (7-bit addresses)
  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPVOL = 7'h02;
  localparam logic [6:0] REG_RHPVOL = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_DFMT   = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] val;
  } cfg_word_t;

  function automatic logic [15:0] pack_word(input logic [6:0] addr, input logic [8:0] val);
    return {addr, val};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search over N_REQ requests, starting just above the last grant.
// The pointer register only moves when the owner commits a grant.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic             CLOCK,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_en_i,
  input  logic [IW-1:0]    upd_idx_i,
  output logic             gnt_any_o,
  output logic [IW-1:0]    gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   sum;

  // Walk from farthest to nearest so the nearest hit above the pointer wins.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    sum       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (req_i[sum[IW-1:0]]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n)        ptr_q <= IW'(N_REQ - 1);
    else if (upd_en_i) ptr_q <= upd_idx_i;
  end

endmodule

// File: rtl/codec_cfg_arbiter.sv
// Shares one I2C register-write engine among N_REQ requesters: round-robin grant,
// slave-address prefix, gap-spaced starts, retry on NACK/timeout, done/err reporting.
module codec_cfg_arbiter
  import codec_cfg_pkg::*;
#(
  parameter int         N_REQ       = 3,
  parameter logic [7:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         GAP_CYC     = 64
) (
  input  logic                   CLOCK,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][15:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       req_err,
  output logic [23:0]            i2c_data,
  output logic                   i2c_go,
  input  logic                   i2c_end,
  input  logic                   i2c_ack,
  output logic                   busy,
  output logic [7:0]             err_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  cfg_state_e       state_q;
  logic [IW-1:0]    g_q;
  logic [TW-1:0]    tmo_q;
  logic [GW-1:0]    gap_q;
  logic [RW-1:0]    rty_q;
  logic             resend_q;
  logic [23:0]      data_q;
  logic             go_q;
  logic [N_REQ-1:0] ready_q, done_q, err_q;
  logic [7:0]       err_cnt_q;
  logic             arb_any;
  logic [IW-1:0]    arb_idx;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .CLOCK     (CLOCK),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .upd_en_i  (state_q == GRANT),
    .upd_idx_i (g_q),
    .gnt_any_o (arb_any),
    .gnt_idx_o (arb_idx)
  );

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      rty_q     <= '0;
      resend_q  <= 1'b0;
      data_q    <= '0;
      go_q      <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      go_q    <= 1'b0;
      unique case (state_q)
        IDLE: if (arb_any) begin
          g_q              <= arb_idx;
          ready_q[arb_idx] <= 1'b1;
          // Word is captured here so i2c_data is already valid while ready is pulsed
          data_q           <= {SLAVE_ADDR, req_data[arb_idx]};
          state_q          <= GRANT;
        end
        GRANT: begin
          rty_q    <= '0;
          resend_q <= 1'b0;
          go_q     <= 1'b1;
          state_q  <= START;
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // A completion pulse beats a coincident timeout
          if (i2c_end && i2c_ack) begin
            done_q[g_q] <= 1'b1;
            resend_q    <= 1'b0;
            gap_q       <= '0;
            state_q     <= GAP;
          end else if (i2c_end || tmo_q == TMO_LAST) begin
            if (rty_q < RTY_MAX) begin
              rty_q    <= rty_q + 1'b1;
              resend_q <= 1'b1;
            end else begin
              err_q[g_q] <= 1'b1;
              resend_q   <= 1'b0;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            go_q    <= resend_q;
            state_q <= resend_q ? START : IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign i2c_data  = data_q;
  assign i2c_go    = go_q;
  assign busy      = (state_q != IDLE);
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Randomized bench for codec_cfg_arbiter: a transaction-level model predicts grant order,
// go/done/err cycle placement, retries and the error counter from the block's rules.
module tb_codec_cfg_arbiter;

  localparam int N   = 3;
  localparam int MR  = 3;
  localparam int TMO = 100;
  localparam int GAP = 16;
  localparam logic [7:0] SA = 8'h34;
  localparam int K_ACK = 0, K_NACK = 1, K_NONE = 2, K_ACKTO = 3;

  logic            CLOCK = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*16-1:0] req_data;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic [23:0]     i2c_data;
  logic            i2c_go, i2c_end, i2c_ack, busy;
  logic [7:0]      err_count;

  codec_cfg_arbiter #(.N_REQ(N), .SLAVE_ADDR(SA), .MAX_RETRY(MR),
                      .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .i2c_data(i2c_data), .i2c_go(i2c_go), .i2c_end(i2c_end), .i2c_ack(i2c_ack),
    .busy(busy), .err_count(err_count)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0, n_mis = 0;
  int cyc = 0, n_go = 0, n_dn = 0, n_er = 0;
  logic [N-1:0] vld;
  logic [15:0]  word [N];
  int mptr, errcnt_m, last_g, rp_mode;
  int plan_k [4];
  int plan_d [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
    cyc++;
    if (i2c_go) n_go++;
    if (req_done != '0) n_dn++;
    if (req_err != '0) n_er++;
  endtask

  task automatic drive();
    req_valid = vld;
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = word[i];
  endtask

  function automatic int mdl_grant();
    for (int k = 1; k <= N; k++)
      if (vld[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic repost();
    for (int i = 0; i < N; i++)
      if (!vld[i] && (rp_mode == 1 || (rp_mode == 2 && $urandom_range(0, 1) == 1))) begin
        vld[i]  = 1'b1;
        word[i] = 16'($urandom);
      end
    // An occasional withdrawal before it is ever granted
    if (rp_mode == 2 && $urandom_range(0, 7) == 0) vld[$urandom_range(0, N-1)] = 1'b0;
  endtask

  task automatic plan_all(input int k, input int d);
    for (int a = 0; a < 4; a++) begin plan_k[a] = k; plan_d[a] = d; end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge busy should fall.
  task automatic run_txn();
    int g, e, go_c, go0, dn0, er0, att, ok;
    logic [15:0] w;
    if (vld == '0) begin
      g = $urandom_range(0, N-1);
      vld[g] = 1'b1; word[g] = 16'($urandom);
    end
    drive();
    go0 = n_go; dn0 = n_dn; er0 = n_er;
    g = mdl_grant();
    tick();
    chk("ready", 32'(req_ready), 32'(1 << g));
    chk("busy", 32'(busy), 32'd1);
    mptr = g; last_g = g; w = word[g];
    vld[g] = 1'b0;
    repost();
    drive();
    tick();
    ok = 0; e = cyc; att = 0;
    for (int a = 0; a <= MR; a++) begin
      att = a + 1;
      chk("go", 32'(i2c_go), 32'd1);
      chk("data", 32'(i2c_data), 32'({SA, w}));
      go_c = cyc;
      e = (plan_k[a] == K_NONE || plan_k[a] == K_ACKTO) ? go_c + TMO : go_c + plan_d[a];
      while (cyc < e) tick();
      if (plan_k[a] != K_NONE) begin
        i2c_end = 1'b1;
        i2c_ack = (plan_k[a] != K_NACK);
      end
      tick();
      i2c_end = 1'b0; i2c_ack = 1'b0;
      if (plan_k[a] == K_ACK || plan_k[a] == K_ACKTO) begin
        chk("done", 32'(req_done), 32'(1 << g));
        chk("no_err", 32'(req_err), 32'd0);
        ok = 1;
        break;
      end
      if (a == MR) begin
        chk("err", 32'(req_err), 32'(1 << g));
        errcnt_m = (errcnt_m < 255) ? errcnt_m + 1 : 255;
        break;
      end
      chk("retry_quiet", 32'({req_done, req_err}), 32'd0);
      while (cyc < e + GAP + 1) tick();
    end
    while (cyc < e + GAP + 1) tick();
    chk("busy_end", 32'(busy), 32'd0);
    chk("n_go", 32'(n_go - go0), 32'(att));
    chk("n_done", 32'(n_dn - dn0), 32'(ok));
    chk("n_err", 32'(n_er - er0), 32'(1 - ok));
    chk("err_count", 32'(err_count), 32'(errcnt_m));
    chk("data_hold", 32'(i2c_data), 32'({SA, w}));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end

  initial begin
    int exp_ord [4];
    int g, dn0, er0;
    exp_ord = '{0, 1, 2, 0};
    rst_n = 1'b0; i2c_end = 1'b0; i2c_ack = 1'b0;
    vld = '0;
    for (int i = 0; i < N; i++) word[i] = '0;
    drive();
    mptr = N - 1; errcnt_m = 0; rp_mode = 0;
    repeat (3) tick();
    chk("rst_ctl", 32'({busy, i2c_go, req_ready, req_done, req_err}), 32'd0);
    chk("rst_data", 32'(i2c_data), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // All requesters continuously valid from reset
    for (int i = 0; i < N; i++) begin vld[i] = 1'b1; word[i] = 16'($urandom); end
    drive();
    rst_n = 1'b1;
    rp_mode = 1;
    plan_all(K_ACK, 3);
    for (int i = 0; i < 4; i++) begin
      run_txn();
      chk("cont_order", 32'(last_g), 32'(exp_ord[i]));
    end
    rp_mode = 0;
    while (vld != '0) run_txn();

    // Single requester, word 0x0C00, ACK after 50 cycles
    vld = 3'b001; word[0] = 16'h0C00;
    plan_all(K_ACK, 50);
    run_txn();
    chk("single_g", 32'(last_g), 32'd0);

    plan_all(K_ACK, 20); plan_k[0] = K_NACK; plan_d[0] = 10;
    run_txn();
    plan_all(K_NACK, 8);
    run_txn();
    plan_all(K_NONE, 1);
    run_txn();
    plan_all(K_NACK, 5); plan_k[0] = K_ACKTO;
    run_txn();

    // Reset while the engine is busy in WAIT
    for (int i = 0; i < N; i++) if (!vld[i]) begin vld[i] = 1'b1; word[i] = 16'($urandom); end
    drive();
    dn0 = n_dn; er0 = n_er;
    g = mdl_grant();
    tick();
    chk("rw_ready", 32'(req_ready), 32'(1 << g));
    vld[g] = 1'b0; drive();
    tick();
    chk("rw_go", 32'(i2c_go), 32'd1);
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rw_ctl", 32'({busy, i2c_go, req_ready, req_done, req_err}), 32'd0);
    chk("rw_data", 32'(i2c_data), 32'd0);
    chk("rw_errcnt", 32'(err_count), 32'd0);
    mptr = N - 1; errcnt_m = 0;
    repeat (3) tick();
    vld[g] = 1'b1; word[g] = 16'($urandom);
    drive();
    rst_n = 1'b1;
    chk("rw_quiet", 32'((n_dn - dn0) + (n_er - er0)), 32'd0);
    plan_all(K_ACK, 4);
    run_txn();
    chk("rw_first", 32'(last_g), 32'd0);

    // Randomized traffic and engine responses
    rp_mode = 2;
    for (int t = 0; t < 30; t++) begin
      for (int a = 0; a < 4; a++) begin
        int r;
        r = $urandom_range(0, 9);
        plan_k[a] = (r < 5) ? K_ACK : (r < 8) ? K_NACK : (r == 8) ? K_NONE : K_ACKTO;
        plan_d[a] = $urandom_range(1, 60);
      end
      run_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
